// File: rtl/gate_truth_checker.sv
// Self-test sequencer for the 2-input lab gates: walks all four input vectors, compares against the truth table.
// Optional macro GATE_CHECK_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  logic       dut_out,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [1:0] op_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic       dut_a_q, dut_b_q, busy_q, done_q, pass_q;
    logic [2:0] err_q;
    logic [3:0] fail_q;

    logic       exp_bit;
    logic       mismatch;
    logic [2:0] err_d;
    logic [1:0] idx_d;

    always_comb begin
        exp_bit = 1'b0;
        case (op_q)
            2'b00: exp_bit = idx_q[1] & idx_q[0];
            2'b01: exp_bit = idx_q[1] | idx_q[0];
            2'b10: exp_bit = idx_q[1] ^ idx_q[0];
            2'b11: exp_bit = ~(idx_q[1] & idx_q[0]);
            default: exp_bit = 1'b0;
        endcase
        mismatch = (dut_out != exp_bit);
        err_d    = err_q + {2'b00, mismatch};
        idx_d    = idx_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            idx_q   <= 2'b00;
            cnt_q   <= 4'd0;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        op_q    <= op_sel;
                        idx_q   <= 2'b00;
                        cnt_q   <= CNT_LOAD;
                        dut_a_q <= 1'b0;
                        dut_b_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 3'd0;
                        fail_q  <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_q[idx_q] <= 1'b1;
                        err_q         <= err_d;
                    end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                    // Leave idx and the drive pins on the failing vector for debug.
                    if (mismatch || idx_q == 2'd3) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= ~mismatch;
                    end else begin
`else
                    if (idx_q == 2'd3) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 3'd0);
                    end else begin
`endif
                        state_q <= SETTLE;
                        idx_q   <= idx_d;
                        dut_a_q <= idx_d[1];
                        dut_b_q <= idx_d[0];
                        cnt_q   <= CNT_LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized bench for gate_truth_checker against a truth-table model of the lab gate and the expected run outcome.
module tb_gate_truth_checker;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic       dut_out;
    logic       dut_a, dut_b, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    // gate model driving dut_out
    logic [1:0] model_op = 2'b00;
    logic [3:0] model_fault = 4'b0000;
    logic       stuck_en = 1'b0;
    logic       stuck_val = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    gate_truth_checker #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .dut_out(dut_out),
        .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic gate_fn(input logic [1:0] op, input int v);
        logic a, b;
        a = (v / 2) % 2 == 1;
        b = v % 2 == 1;
        case (op)
            2'd0: return a && b;
            2'd1: return a || b;
            2'd2: return a != b;
            default: return !(a && b);
        endcase
    endfunction

    always_comb begin
        if (stuck_en) dut_out = stuck_val;
        else          dut_out = gate_fn(model_op, 2 * int'(dut_a) + int'(dut_b)) ^ model_fault[{dut_a, dut_b}];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zero"}, {dut_a, dut_b, busy, done, pass, err_count, fail_vec[0]}, 8'h00);
        chk({tag, "_fvec"}, {4'h0, fail_vec}, 8'h00);
    endtask

    // One complete run; poke=1 pulses start and flips op_sel at edge 5 of the run.
    task automatic run(input string tag, input logic [1:0] op, input bit poke);
        int v_out, exp_err, first_fail, exp_done_edge, edges, vlast;
        logic [3:0] exp_fail;
        logic obs_bit;
        exp_err = 0; exp_fail = 4'b0; first_fail = -1;
        for (int v = 0; v < 4; v++) begin
            obs_bit = stuck_en ? stuck_val : (gate_fn(model_op, v) ^ model_fault[v]);
            if (obs_bit != gate_fn(op, v)) begin
                exp_err++;
                exp_fail[v] = 1'b1;
                if (first_fail < 0) first_fail = v;
            end
        end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        if (first_fail >= 0) begin
            exp_err = 1;
            exp_fail = 4'b0;
            exp_fail[first_fail] = 1'b1;
            vlast = first_fail;
        end else vlast = 3;
`else
        vlast = 3;
`endif
        // start edge counts as edge 1; each vector spends S settle + 1 sample edges
        exp_done_edge = (vlast + 1) * (S + 1) + 1;

        @(negedge clk);
        op_sel = op;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 1;
        chk({tag, "_busy_after_start"}, {6'b0, busy, done}, 8'b10);
        while (!done && edges < 60) begin
            @(negedge clk);
            v_out = (edges - 1) / (S + 1);
            chk({tag, "_vector"}, {6'b0, dut_a, dut_b}, 8'(v_out));
            if (poke && edges == 4) begin
                start = 1'b1;
                op_sel = ~op;
            end
            @(posedge clk);
            edges++;
            #1;
            if (poke && edges == 5) start = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done_edge"}, 8'(edges), 8'(exp_done_edge));
        chk({tag, "_done_busy"}, {6'b0, done, busy}, 8'b10);
        chk({tag, "_err_count"}, {5'b0, err_count}, 8'(exp_err));
        chk({tag, "_fail_vec"}, {4'b0, fail_vec}, {4'b0, exp_fail});
        chk({tag, "_pass"}, {7'b0, pass}, {7'b0, exp_err == 0});
        chk({tag, "_ab_in_done"}, {6'b0, dut_a, dut_b}, 8'(vlast));
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, {done, err_count, fail_vec}, {1'b1, 3'(exp_err), exp_fail});
    endtask

    initial begin
        #1;
        chk_all_zero("reset_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        model_op = 2'd0;
        run("and_ok", 2'd0, 1'b0);

        model_op = 2'd2;
        run("xor_ok", 2'd2, 1'b0);

        stuck_en = 1'b1; stuck_val = 1'b0;
        run("or_stuck0", 2'd1, 1'b0);
        stuck_en = 1'b0;

        // restart from DONE with a NAND model
        model_op = 2'd3;
        run("nand_restart", 2'd3, 1'b0);

        model_op = 2'd1;
        run("or_poke", 2'd1, 1'b1);

        // reset during the second SETTLE
        @(negedge clk);
        op_sel = 2'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_midrun");
        @(negedge clk);
        chk_all_zero("rst_midrun_held");
        rst = 1'b0;
        run("after_rst", 2'd1, 1'b0);

        stuck_en = 1'b1; stuck_val = 1'b1;
        run("and_stuck1", 2'd0, 1'b0);
        stuck_en = 1'b0;

        for (int i = 0; i < 10; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            model_op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : op;
            model_fault = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            run("rand", op, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
